// File: rtl/pcd8544_spi_tx_if.sv
// Upstream byte port of the PCD8544 SPI transmitter: valid/ready handshake
// carrying one display byte plus its D/C tag.
interface pcd8544_spi_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_dc;

    modport master (
        output in_valid,
        output in_data,
        output in_dc,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_dc,
        output in_ready
    );
endinterface

// File: rtl/pcd8544_spi_tx.sv
// PCD8544 (Nokia 5110) byte transmitter: FIFO, panel reset sequence, SPI mode 0 shifter.
// Define PCD8544_TX_CE_HOLD_EN to keep ce low across queued bytes and skip the inter-byte gap.
module pcd8544_spi_tx #(
    parameter int CLK_DIV    = 8,
    parameter int RST_CYCLES = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    pcd8544_spi_tx_if.slave        up,
    output logic                   mosi,
    output logic                   sclk,
    output logic                   ce,
    output logic                   dc,
    output logic                   lcd_rst,
    output logic                   busy,
    output logic                   byte_done
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int CNT_MAX = (RST_CYCLES > CLK_DIV) ? RST_CYCLES : CLK_DIV;
    localparam int TW      = $clog2(CNT_MAX + 1);

    localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] DIV_LAST = TW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        RST_PULSE,
        RST_WAIT,
        IDLE,
        SHIFT,
        GAP
    } state_t;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic          fifoFull;
    logic          fifoEmpty;
    logic          push;
    logic          pop;
    logic [8:0]    headEntry;

    state_t        state_q,  state_d;
    logic [TW-1:0] tmr_q,    tmr_d;
    logic [2:0]    bitCnt_q, bitCnt_d;
    logic [7:0]    shReg_q,  shReg_d;
    logic          sclk_q,   sclk_d;
    logic          mosi_q,   mosi_d;
    logic          ce_q,     ce_d;
    logic          dc_q,     dc_d;
    logic          lcdRst_q, lcdRst_d;
    logic          done_q,   done_d;
    logic          startByte;
    logic          tmrDone;

    assign fifoFull    = (count_q == CW'(FIFO_DEPTH));
    assign fifoEmpty   = (count_q == '0);
    assign push        = up.in_valid && !fifoFull;
    assign headEntry   = mem_q[rdPtr_q];
    assign up.in_ready = !fifoFull;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= {up.in_dc, up.in_data};
        end
    end

    // Pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RST_PULSE;
            tmr_q    <= '0;
            bitCnt_q <= '0;
            shReg_q  <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            ce_q     <= 1'b1;
            dc_q     <= 1'b0;
            lcdRst_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            bitCnt_q <= bitCnt_d;
            shReg_q  <= shReg_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            ce_q     <= ce_d;
            dc_q     <= dc_d;
            lcdRst_q <= lcdRst_d;
            done_q   <= done_d;
        end
    end

    assign tmrDone = (tmr_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bitCnt_d  = bitCnt_q;
        shReg_d   = shReg_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ce_d      = ce_q;
        dc_d      = dc_q;
        lcdRst_d  = lcdRst_q;
        done_d    = 1'b0;
        startByte = 1'b0;
        pop       = 1'b0;

        case (state_q)
            RST_PULSE: begin
                lcdRst_d = 1'b0;
                if (tmr_q == RST_LAST) begin
                    tmr_d    = '0;
                    lcdRst_d = 1'b1;
                    state_d  = RST_WAIT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            RST_WAIT: begin
                if (tmr_q == RST_LAST) begin
                    tmr_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            IDLE: begin
                if (!fifoEmpty) begin
                    startByte = 1'b1;
                end
            end

            // Low half then high half per bit; the next bit is presented on the falling edge.
            SHIFT: begin
                if (!tmrDone) begin
                    tmr_d = tmr_q + 1'b1;
                end else begin
                    tmr_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bitCnt_q != 3'd0) begin
                        sclk_d   = 1'b0;
                        bitCnt_d = bitCnt_q - 3'd1;
                        shReg_d  = shReg_q << 1;
                        mosi_d   = shReg_q[6];
                    end else begin
                        sclk_d = 1'b0;
                        done_d = 1'b1;
`ifdef PCD8544_TX_CE_HOLD_EN
                        if (!fifoEmpty) begin
                            startByte = 1'b1;
                        end else begin
                            ce_d    = 1'b1;
                            state_d = GAP;
                        end
`else
                        ce_d    = 1'b1;
                        state_d = GAP;
`endif
                    end
                end
            end

            // A queued byte pops on the gap's last cycle so ce stays high exactly CLK_DIV cycles.
            GAP: begin
                if (!tmrDone) begin
                    tmr_d = tmr_q + 1'b1;
                end else begin
                    tmr_d = '0;
                    if (!fifoEmpty) begin
                        startByte = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = RST_PULSE;
                tmr_d   = '0;
            end
        endcase

        if (startByte) begin
            pop      = 1'b1;
            state_d  = SHIFT;
            tmr_d    = '0;
            bitCnt_d = 3'd7;
            shReg_d  = headEntry[7:0];
            mosi_d   = headEntry[7];
            dc_d     = headEntry[8];
            ce_d     = 1'b0;
            sclk_d   = 1'b0;
        end
    end

    assign mosi      = mosi_q;
    assign sclk      = sclk_q;
    assign ce        = ce_q;
    assign dc        = dc_q;
    assign lcd_rst   = lcdRst_q;
    assign byte_done = done_q;
    assign busy      = (state_q == RST_PULSE) || (state_q == RST_WAIT) ||
                       (state_q == SHIFT) || !fifoEmpty;

endmodule
